// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store stage over a req/ack data-memory port
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs2_val,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [1:0]  r_fault;
  logic [7:0]  r_cnt;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata, r_load_data;
  logic [3:0]  r_mem_be;

  logic [31:0] w_addr, w_wdata, w_ld;
  logic [3:0]  w_be;
  logic [15:0] w_lane;
  logic        w_illegal, w_misal, w_accept, w_go, w_ack, w_timeout;

  assign w_addr    = i_rs1_val + i_imm;
  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_illegal = (i_is_load == i_is_store)
                   || (i_is_load  && !(i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                   || (i_is_store && !(i_funct3 inside {3'b000, 3'b001, 3'b010}));
  assign w_misal   = ((i_funct3[1:0] == 2'b01) && w_addr[0])
                   || ((i_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_go      = w_accept && !w_illegal && !w_misal;
  assign w_ack     = (r_state == S_REQ) && i_mem_ack;
  assign w_timeout = (r_state == S_REQ) && !i_mem_ack && (r_cnt == LP_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rs2_val;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{i_rs2_val[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_addr[1:0];
        w_wdata = {2{i_rs2_val[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select shifts the addressed byte/half down to bit 0 before extension.
  assign w_lane = 16'(i_mem_rdata >> {r_lane, 3'b000});

  always_comb begin
    w_ld = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_ld = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld = {{16{w_lane[15]}}, w_lane};
      3'b100:  w_ld = {24'd0, w_lane[7:0]};
      3'b101:  w_ld = {16'd0, w_lane};
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_illegal || w_misal) ? S_DONE : S_REQ;
      S_REQ:   if (w_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_fault     <= 2'd0;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_funct3 <= i_funct3;
        r_lane   <= w_addr[1:0];
        r_fault  <= w_illegal ? 2'b10 : (w_misal ? 2'b01 : 2'b00);
      end
      if (w_go) begin
        r_cnt       <= 8'd0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= i_is_store;
        r_mem_addr  <= {w_addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
      if (w_ack) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) r_load_data <= w_ld;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_timeout) begin
          r_mem_req <= 1'b0;
          r_fault   <= 2'b11;
        end
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_fault     = o_done ? r_fault : 2'b00;
  assign o_load_data = r_load_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage of the processor. It consumes the sign-extended immediate from the immediate generator together with register operands and adds `rs1_val + imm` to form the address. It then executes one load (LB, LH, LW, LBU, LHU) or store (SB, SH, SW) over a request/acknowledge memory port. It returns the extended load data and a completion pulse, and stalls the core while an access is in flight.

## Interface
- `MAX_WAIT`, default 255: number of `REQ` cycles without `mem_ack` before the access is aborted; legal range is 1..255.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: access request, sampled only in `IDLE`.
- `is_load`, in, 1: operation is a load.
- `is_store`, in, 1: operation is a store.
- `funct3`, in, 3: access type.
- `rs1_val`, in, 32: base register value.
- `imm`, in, 32: sign-extended offset from the immediate generator.
- `rs2_val`, in, 32: store data.
- `busy`, out, 1: equals `state != IDLE`; the core stalls while it is high.
- `done`, out, 1: one-cycle completion pulse.
- `load_data`, out, 32: extended load result; held until the next load completes.
- `fault`, out, 2: valid while `done`=1 and 0 otherwise. 00 = ok, 01 = misaligned, 10 = illegal, 11 = timeout.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: 1 = write.
- `mem_addr`, out, 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be`, out, 4: byte enables.
- `mem_wdata`, out, 32: lane-replicated store data.
- `mem_ack`, in, 1: memory completion. For loads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`, in, 32: read word.

## Operation
- States and transitions:
  - `IDLE` --start, legal, aligned--> `REQ`.
  - `IDLE` --start, illegal or misaligned--> `DONE`. No memory request is issued.
  - `REQ` --`mem_ack`--> `DONE`.
  - `REQ` --wait count reaches `MAX_WAIT`--> `DONE` with fault 11.
  - `DONE` --> `IDLE`, unconditionally.
- Address: `addr = rs1_val + imm`, 32-bit, wraps modulo 2^32, no overflow flag. Address, `funct3`, direction and `rs2_val` are registered at the accepting `start` edge. Inputs may change afterwards.
- Illegal when any of the following holds:
  - `is_load` and `is_store` are equal.
  - A load has `funct3` ∉ {000, 001, 010, 100, 101}.
  - A store has `funct3` ∉ {000, 001, 010}.
- Misaligned: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0. Illegal takes priority over misaligned.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Store data: byte `{4{rs2_val[7:0]}}`, half `{2{rs2_val[15:0]}}`, word `rs2_val`.
- Load extraction: select the lane given by `addr[1:0]`.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
  - `load_data` updates only on an acknowledged load. Stores, faults and timeouts leave it unchanged.
- Wait counter: cleared on entry to `REQ` and increments each `REQ` cycle with `mem_ack`=0. When it reaches `MAX_WAIT`, `mem_req` drops.

## Timing
- Reset values: `busy`, `done`, `mem_req` and `mem_we` are 0. `mem_addr`, `mem_be`, `mem_wdata`, `load_data` and `fault` are 0. State is `IDLE` and the counter is 0.
- Reset asserted mid-access:
  - All outputs and state return to their reset values immediately, and no request is retained.
  - A `mem_ack` arriving after reset is ignored.
- Best case:
  - cycle 0: `start` accepted.
  - cycle 1: `mem_req`=1, `mem_ack`=1.
  - cycle 2: `done`=1.
  - cycle 3: back in `IDLE`, `start` accepted again.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stay constant while `mem_req`=1. `mem_req` deasserts in the cycle after ack.
- A fault detected at accept gives `done` with fault 01 or 10 at cycle 1. `mem_req` stays 0 throughout.
- Timeout: with no ack, `mem_req` is high for exactly `MAX_WAIT` cycles, followed by `done` with fault 11 in the next cycle.
- `start` while `busy`=1 is ignored and not queued. `mem_ack` outside `REQ` is ignored.
- `done` never lasts longer than 1 cycle. `load_data` is valid from the `done` cycle onwards.

## Test plan
- LW with `rs1_val`=0x1000, `imm`=0xFFFFFFFC, ack after 3 cycles with rdata 0xDEADBEEF:
  - `mem_addr` = 0x0FFC, `mem_be` = 1111, `mem_req` high for 3 cycles.
  - `done` pulses with fault 00 and `load_data` = 0xDEADBEEF.
- LB/LBU at `addr[1:0]`=11 with rdata 0x80FF_0000 and immediate ack:
  - LB gives `load_data` = 0xFFFFFF80.
  - LBU gives 0x00000080.
  - Both use `mem_be` = 1000.
- SH at addr 0x2002 with `rs2_val`=0x1234ABCD:
  - `mem_we`=1, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD.
  - `load_data` is unchanged.
- Fault cases at accept:
  - LW at 0x2001: `done` at cycle 1 with fault 01 and `mem_req` never asserted.
  - `is_load` = `is_store` = 1: fault 10.
  - Store with `funct3`=100: fault 10.
- `MAX_WAIT`=4 and no ack: `mem_req` high for 4 cycles, then `done` with fault 11.
  - A late ack 2 cycles afterwards is ignored.
- Reset and wrap:
  - `rst_n` pulsed low during `REQ`: all outputs return to 0 asynchronously.
  - After release, a new LW completes normally.
  - `start` pulsed during `busy`: no second access.
  - Address wrap with `rs1_val`=0xFFFFFFFC and `imm`=8: `mem_addr` = 0x00000004.
